// File: rtl/bcd_add_seq.sv
// Sequential packed-BCD adder/subtractor, DPC digits per clock.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (in_ready only while idle)
//   a, b                - packed BCD operands, digit 0 in [3:0]
//   cin                 - decimal carry-in, add mode only
//   sub                 - 0: a+b+cin, 1: a-b (nine's complement of b, carry-in 1)
//   out_valid/out_ready - result handshake
//   sum, cout, err      - result digits, final carry (no-borrow in sub), bad-nibble flag
module bcd_add_seq #(
    parameter int unsigned DIGITS = 100,
    parameter int unsigned DPC    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned DATA_W   = 4 * DIGITS;
    localparam int unsigned CHUNK_W  = 4 * DPC;
    localparam int unsigned N_CHUNKS = DIGITS / DPC;
    localparam int unsigned CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    // Reject configurations where the operand does not split into whole chunks.
    generate
        if ((DIGITS % DPC) != 0) begin : g_bad_cfg
            $error("bcd_add_seq: DIGITS must be a multiple of DPC");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_last;

    logic [CNT_W-1:0]    r_cnt;
    logic                r_carry;
    logic                r_sub;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_sum;
    logic                r_cout;
    logic                r_err;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [CHUNK_W-1:0]  w_a_chunk;
    logic [CHUNK_W-1:0]  w_b_chunk;
    logic [CHUNK_W-1:0]  w_chunk_sum;
    logic                w_chunk_cout;
    logic                w_chunk_err;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign err       = r_err;

    assign w_last = (r_cnt == CNT_W'(N_CHUNKS - 1));

    // Next-state logic and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Select the operand chunk addressed by the chunk counter.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < int'(N_CHUNKS); k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_chunk = r_a[k*CHUNK_W +: CHUNK_W];
                w_b_chunk = r_b[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    // Ripple DPC decimal digit adders; invalid nibbles flag err but still add.
    always_comb begin
        logic       c;
        logic [3:0] da;
        logic [3:0] db_raw;
        logic [3:0] db;
        logic [4:0] s;
        c           = r_carry;
        w_chunk_sum = '0;
        w_chunk_err = 1'b0;
        for (int i = 0; i < int'(DPC); i++) begin
            da     = w_a_chunk[4*i +: 4];
            db_raw = w_b_chunk[4*i +: 4];
            if ((da > 4'd9) || (db_raw > 4'd9)) begin
                w_chunk_err = 1'b1;
            end
            // 4-bit wrap gives the (9-d) mod 16 complement for invalid digits too.
            db = r_sub ? (4'd9 - db_raw) : db_raw;
            s  = 5'(da) + 5'(db) + 5'(c);
            if (s >= 5'd10) begin
                w_chunk_sum[4*i +: 4] = 4'(s - 5'd10);
                c                     = 1'b1;
            end else begin
                w_chunk_sum[4*i +: 4] = s[3:0];
                c                     = 1'b0;
            end
        end
        w_chunk_cout = c;
    end

    // State register, handshake flags and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_sub   <= sub;
                r_carry <= sub | cin;
                r_err   <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_carry <= w_chunk_cout;
                r_err   <= r_err | w_chunk_err;
                for (int k = 0; k < int'(N_CHUNKS); k++) begin
                    if (r_cnt == CNT_W'(k)) begin
                        r_sum[k*CHUNK_W +: CHUNK_W] <= w_chunk_sum;
                    end
                end
                if (w_last) begin
                    r_cnt  <= '0;
                    r_cout <= w_chunk_cout;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_add_seq.sv
// Self-checking bench: small (8 digits, 2/clk) and large (100 digits, 4/clk) instances.
module tb_bcd_add_seq;

    localparam int unsigned SD = 8;
    localparam int unsigned LD = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic            s_rst, s_in_valid, s_in_ready, s_cin, s_sub;
    logic            s_out_valid, s_out_ready, s_cout, s_err;
    logic [4*SD-1:0] s_a, s_b, s_sum;
    // large instance
    logic            l_rst, l_in_valid, l_in_ready, l_cin, l_sub;
    logic            l_out_valid, l_out_ready, l_cout, l_err;
    logic [4*LD-1:0] l_a, l_b, l_sum;

    int n_checks = 0;
    int n_errors = 0;

    bcd_add_seq #(.DIGITS(SD), .DPC(2)) u_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .err(s_err)
    );

    bcd_add_seq #(.DIGITS(LD), .DPC(4)) u_large (
        .clk(clk), .rst(l_rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .a(l_a), .b(l_b), .cin(l_cin), .sub(l_sub),
        .out_valid(l_out_valid), .out_ready(l_out_ready),
        .sum(l_sum), .cout(l_cout), .err(l_err)
    );

    task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal reference: schoolbook add with carry, or subtract with borrow.
    function automatic void ref_model(input logic [399:0] av, input logic [399:0] bv,
                                      input logic ci, input logic sb, input int nd,
                                      output logic [399:0] sv, output logic co);
        int c;
        int d;
        sv = '0;
        c  = sb ? 0 : int'(ci);
        for (int i = 0; i < nd; i++) begin
            int da;
            int db;
            da = int'(av[4*i +: 4]);
            db = int'(bv[4*i +: 4]);
            if (!sb) begin
                d = da + db + c;
                c = d / 10;
                d = d % 10;
            end else begin
                d = da - db - c;
                if (d < 0) begin
                    d = d + 10;
                    c = 1;
                end else begin
                    c = 0;
                end
            end
            sv[4*i +: 4] = 4'(d);
        end
        co = sb ? (c == 0) : (c == 1);
    endfunction

    function automatic logic [399:0] rand_bcd(input int nd);
        logic [399:0] v;
        v = '0;
        for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic s_start(input logic [31:0] av, input logic [31:0] bv,
                           input logic ci, input logic sb);
        chk("s_in_ready_before_accept", 400'(s_in_ready), 400'(1));
        s_a = av; s_b = bv; s_cin = ci; s_sub = sb; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        // scramble inputs while running; result must not change
        s_a = $urandom; s_b = $urandom; s_cin = 1'($urandom); s_sub = 1'($urandom);
    endtask

    task automatic s_wait(output int lat);
        lat = 0;
        while (s_out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic s_release();
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("s_in_ready_after_release", 400'(s_in_ready), 400'(1));
        chk("s_out_valid_after_release", 400'(s_out_valid), 400'(0));
    endtask

    task automatic s_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic sb,
                        input logic [31:0] es, input logic ec, input logic ee);
        int lat;
        s_start(av, bv, ci, sb);
        s_wait(lat);
        chk({tag, "_latency"}, 400'(lat), 400'(4));
        chk({tag, "_sum"}, 400'(s_sum), 400'(es));
        chk({tag, "_cout"}, 400'(s_cout), 400'(ec));
        chk({tag, "_err"}, 400'(s_err), 400'(ee));
        s_release();
        chk({tag, "_sum_held"}, 400'(s_sum), 400'(es));
    endtask

    task automatic l_op(input string tag, input logic [399:0] av, input logic [399:0] bv,
                        input logic ci, input logic sb);
        int lat;
        logic [399:0] es;
        logic ec;
        ref_model(av, bv, ci, sb, int'(LD), es, ec);
        chk({tag, "_in_ready"}, 400'(l_in_ready), 400'(1));
        l_a = av; l_b = bv; l_cin = ci; l_sub = sb; l_in_valid = 1'b1;
        tick();
        l_in_valid = 1'b0;
        l_a = rand_bcd(int'(LD)); l_b = rand_bcd(int'(LD)); l_sub = ~sb;
        lat = 0;
        while (l_out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 400'(lat), 400'(25));
        chk({tag, "_sum"}, l_sum, es);
        chk({tag, "_cout"}, 400'(l_cout), 400'(ec));
        chk({tag, "_err"}, 400'(l_err), 400'(0));
        l_out_ready = 1'b1;
        tick();
        l_out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 400'(l_in_ready), 400'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [399:0] va, vb, vs;
        logic         vc, ci, sb;
        int           lat;

        s_rst = 1'b1; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        s_out_ready = 1'b0;
        l_rst = 1'b1; l_in_valid = 1'b0; l_a = '0; l_b = '0; l_cin = 1'b0; l_sub = 1'b0;
        l_out_ready = 1'b0;
        tick();
        tick();
        s_rst = 1'b0;
        l_rst = 1'b0;

        // reset state
        chk("rst_in_ready", 400'(s_in_ready), 400'(1));
        chk("rst_out_valid", 400'(s_out_valid), 400'(0));
        chk("rst_sum", 400'(s_sum), 400'(0));
        chk("rst_cout", 400'(s_cout), 400'(0));
        chk("rst_err", 400'(s_err), 400'(0));
        chk("rst_l_in_ready", 400'(l_in_ready), 400'(1));

        // directed cases
        s_op("carry_ripple", 32'h9999_9999, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        s_op("sub_pos", 32'h0000_1234, 32'h0000_0235, 1'b0, 1'b1, 32'h0000_0999, 1'b1, 1'b0);
        s_op("sub_neg", 32'h0000_0235, 32'h0000_1234, 1'b1, 1'b1, 32'h9999_9001, 1'b0, 1'b0);
        s_op("bad_a", 32'h0000_000A, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b1);
        s_op("bad_b_sub", 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
        s_op("cin_add", 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
        s_op("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // backpressure: result held, in_valid pulses ignored
        s_start(32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
        s_wait(lat);
        chk("bp_latency", 400'(lat), 400'(4));
        for (int k = 0; k < 5; k++) begin
            s_in_valid = (k % 2) == 0;
            s_a = $urandom; s_b = $urandom;
            tick();
            chk("bp_out_valid", 400'(s_out_valid), 400'(1));
            chk("bp_in_ready", 400'(s_in_ready), 400'(0));
            chk("bp_sum", 400'(s_sum), 400'(32'h4444_6666));
        end
        s_in_valid = 1'b0;
        s_release();
        tick();
        chk("bp_no_stray_accept", 400'(s_in_ready), 400'(1));
        chk("bp_sum_after", 400'(s_sum), 400'(32'h4444_6666));

        // reset on the second RUN cycle aborts the operation
        s_start(32'h5555_5555, 32'h4444_4444, 1'b0, 1'b0);
        tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk("abort_in_ready", 400'(s_in_ready), 400'(1));
        chk("abort_out_valid", 400'(s_out_valid), 400'(0));
        chk("abort_sum", 400'(s_sum), 400'(0));
        chk("abort_cout", 400'(s_cout), 400'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_quiet", 400'(s_out_valid), 400'(0));
        end
        s_op("after_abort", 32'h0000_0758, 32'h0000_0243, 1'b1, 1'b0, 32'h0000_1002, 1'b0, 1'b0);

        // random small operations
        for (int t = 0; t < 8; t++) begin
            va = rand_bcd(int'(SD));
            vb = rand_bcd(int'(SD));
            ci = 1'($urandom);
            sb = 1'(t % 2);
            ref_model(va, vb, ci, sb, int'(SD), vs, vc);
            s_op("s_rand", va[31:0], vb[31:0], ci, sb, vs[31:0], vc, 1'b0);
        end

        // large instance: random operands both modes, plus equal-operand subtract
        for (int t = 0; t < 6; t++) begin
            va = rand_bcd(int'(LD));
            vb = rand_bcd(int'(LD));
            l_op("l_rand", va, vb, 1'($urandom), 1'(t % 2));
        end
        va = rand_bcd(int'(LD));
        l_op("l_sub_equal", va, va, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_add_seq.md
BCD_ADD_SEQ -- requirements
Module: bcd_add_seq

Interface
REQ-001 SHALL have parameter DIGITS, default 100: operand width in BCD digits.
REQ-002 SHALL have parameter DPC, default 4: digits processed per clock; DIGITS mod DPC SHALL be 0, else elaboration error.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have ports a and b, input, 4*DIGITS each: packed BCD operands, digit 0 in [3:0].
REQ-008 SHALL have port cin, input, 1: decimal carry-in (add mode only).
REQ-009 SHALL have port sub, input, 1: 0 = a+b+cin; 1 = a-b.
REQ-010 SHALL have port out_valid, output, 1: result valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port sum, output, 4*DIGITS: packed BCD result.
REQ-013 SHALL have port cout, output, 1: final decimal carry; in sub mode 1 = no borrow (a>=b).
REQ-014 SHALL have port err, output, 1: some a or b nibble of the operation exceeded 9.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; input accepted on the edge where in_valid & in_ready.
REQ-017 On accept: latch a, b, sub, effective carry (sub ? 1 : cin); clear err accumulator; enter RUN; set chunk counter to 0.
REQ-018 sub=1 SHALL replace each b digit with its nine's complement (9-d) mod 16 and ignore cin.
REQ-019 Each RUN cycle SHALL add the lowest DPC unprocessed digits in a ripple chain with the stored carry, then store the carry-out for the next chunk.
REQ-020 Per digit: s = a_d + b'_d + c; s>=10 -> digit (s-10) mod 16, carry 1; else digit s, carry 0.
REQ-021 Any a_d or b_d (before complement) > 9 SHALL set err; digit arithmetic per REQ-020 still applied.
REQ-022 RUN SHALL last exactly DIGITS/DPC cycles; counter wraps to 0 on leaving RUN.
REQ-023 out_valid SHALL rise exactly DIGITS/DPC cycles after the accept edge.
REQ-024 sum, cout, err SHALL be stable while out_valid=1 and hold their value until the next accept.
REQ-025 DONE SHALL hold until out_ready=1; that edge returns to IDLE; in_ready=1 the following cycle, no overlap.
REQ-026 in_valid, a, b, cin, sub SHALL be ignored outside IDLE; changes during RUN do not affect the result.
REQ-027 DPC=DIGITS SHALL give 1-cycle latency with the same protocol.
REQ-028 Sub result with cout=0 SHALL be the ten's complement of (b-a) over DIGITS digits.

Reset
REQ-029 rst=1 SHALL force IDLE, counter 0, carry 0, in_ready=1 (after the edge), out_valid=0, sum=0, cout=0, err=0.
REQ-030 rst SHALL take priority over all handshakes, aborting RUN or DONE without emitting a result.

Verification (DIGITS=8, DPC=2 unless noted)
REQ-031 a=0x99999999, b=0x00000001, cin=0, sub=0 -> out_valid 4 cycles after accept, sum=0x00000000, cout=1, err=0.
REQ-032 a=0x00001234, b=0x00000235, sub=1 -> sum=0x00000999, cout=1; swap operands -> sum=0x99999001, cout=0.
REQ-033 a=0x0000000A, b=0, cin=0, sub=0 -> err=1, sum=0x00000010, cout=0.
REQ-034 out_ready held 0 for 5 cycles after out_valid -> out_valid, sum stable; in_ready=0 throughout; in_valid pulses ignored.
REQ-035 rst asserted on 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; new operation completes correctly.
REQ-036 DIGITS=100, DPC=4, random valid BCD operands both modes -> latency 25 cycles, sum/cout match reference decimal model.
